// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target answering one address, fronting an auto-incrementing byte register file
// Define I2C_TGT_STRETCH_EN to hold scl low for STRETCH_CYCLES clocks after every ACK bit.
module i2c_target_regfile #(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22,
    parameter int MEM_DEPTH = 16,
`ifdef I2C_TGT_STRETCH_EN
    parameter int STRETCH_CYCLES = 8,
`endif
    localparam int PTR_W = $clog2(MEM_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      busy_o,
    output logic                      wr_valid_o,
    output logic [PTR_W-1:0]          wr_addr_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic [PTR_W-1:0]          ptr_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    localparam int MSB = I2C_DATA_WIDTH - 1;
    localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] ALL_BITS = 4'(I2C_DATA_WIDTH);

    state_t                  state, state_n;
    logic [2:0]              scl_sync, sda_sync;
    logic [3:0]              bit_cnt, cnt_n;
    logic [MSB:0]            shreg, sh_n, sh_in, rd_byte, rd_next;
    logic [PTR_W-1:0]        ptr, ptr_n, ptr_inc;
    logic                    sda_q, sda_n, busy_q, busy_n, wr_en;
    logic                    scl_rise, scl_fall, start_evt, stop_evt, addr_hit;
    logic                    wr_valid_q;
    logic [PTR_W-1:0]        wr_addr_q;
    logic [MSB:0]            wr_data_q;
    logic [MSB:0]            mem [MEM_DEPTH];

    // [1] is the synchronized wire, [2] its previous value for edge detection
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_evt = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
    assign stop_evt  = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];

    assign sh_in    = {shreg[MSB-1:0], sda_sync[1]};
    assign addr_hit = (sh_in[MSB -: I2C_ADDR_WIDTH] == TARGET_ADDR) && (sh_in[MSB -: I2C_ADDR_WIDTH] != '0);
    assign ptr_inc  = ptr + PTR_W'(1);
    assign rd_byte  = mem[ptr];
    assign rd_next  = mem[ptr_inc];

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        ptr_n   = ptr;
        sda_n   = sda_q;
        busy_n  = busy_q;
        wr_en   = 1'b0;
        if (start_evt) begin
            state_n = ADDR;
            cnt_n   = '0;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
        end else if (stop_evt) begin
            state_n = IDLE;
            cnt_n   = '0;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sh_n  = sh_in;
                    cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = addr_hit ? ADDR_ACK : IGNORE;
                        busy_n  = addr_hit;
                    end
                end
                // first falling edge pulls sda low, the next one ends the ACK bit
                ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                    if (sda_q) begin
                        sda_n = 1'b0;
                    end else begin
                        sda_n = 1'b1;
                        cnt_n = '0;
                        if (state != ADDR_ACK) begin
                            state_n = WR_DATA;
                        end else if (shreg[0]) begin
                            state_n = RD_DATA;
                            sda_n   = rd_byte[MSB];
                            sh_n    = {rd_byte[MSB-1:0], 1'b0};
                            cnt_n   = 4'd1;
                        end else begin
                            state_n = PTR;
                        end
                    end
                end
                PTR, WR_DATA: if (scl_rise) begin
                    sh_n  = sh_in;
                    cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        if (state == PTR) begin
                            ptr_n   = sh_in[PTR_W-1:0];
                            state_n = PTR_ACK;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr_inc;
                            state_n = WR_ACK;
                        end
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == ALL_BITS) begin
                        sda_n   = 1'b1;
                        state_n = RD_ACK;
                    end else begin
                        sda_n = shreg[MSB];
                        sh_n  = {shreg[MSB-1:0], 1'b0};
                        cnt_n = bit_cnt + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_sync[1]) begin
                        ptr_n   = ptr_inc;
                        sh_n    = rd_next;
                        cnt_n   = '0;
                        state_n = RD_DATA;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            scl_sync   <= {scl_sync[1:0], scl_i};
            sda_sync   <= {sda_sync[1:0], sda_i};
            state      <= state_n;
            bit_cnt    <= cnt_n;
            shreg      <= sh_n;
            ptr        <= ptr_n;
            sda_q      <= sda_n;
            busy_q     <= busy_n;
            wr_valid_q <= wr_en;
            if (wr_en) begin
                mem[ptr]  <= sh_in;
                wr_addr_q <= ptr;
                wr_data_q <= sh_in;
            end
        end
    end

`ifdef I2C_TGT_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    logic          ack_end, scl_q;
    logic [SW-1:0] stretch_cnt;

    // falling edge that closes an ACK bit; a read ACK is closed inside RD_DATA
    assign ack_end = scl_fall && (((state == ADDR_ACK || state == PTR_ACK || state == WR_ACK) && !sda_q)
                                  || (state == RD_DATA && bit_cnt == 4'd0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stretch_cnt <= '0;
            scl_q       <= 1'b1;
        end else if (start_evt || stop_evt) begin
            stretch_cnt <= '0;
            scl_q       <= 1'b1;
        end else if (ack_end) begin
            stretch_cnt <= SW'(STRETCH_CYCLES - 1);
            scl_q       <= 1'b0;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - SW'(1);
        end else begin
            scl_q <= 1'b1;
        end
    end
    assign scl_o = scl_q;
`else
    assign scl_o = 1'b1;
`endif

    assign sda_o      = sda_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign ptr_o      = ptr;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - bench driving i2c_target_regfile as an I2C controller against a register-file model
module tb_i2c_target_regfile;
    localparam int Q = 60;  // quarter scl period in ns, 6 clk_i cycles

    logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_o, sda_o, busy, wr_valid;
    logic [3:0] wr_addr, ptr;
    logic [7:0] wr_data;
    logic       scl_bus, sda_bus;

    int          vectors = 0, miscompares = 0;
    logic [7:0]  model_mem [16];
    int          model_ptr;
    logic [11:0] wr_q[$], exp_q[$];
    logic [7:0]  rd_q[$];
    int          stretch_runs[$];
    int          run_len = 0;
    bit          sda_low_seen = 0;

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    i2c_target_regfile dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_o(scl_o), .sda_o(sda_o), .busy_o(busy), .wr_valid_o(wr_valid),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .ptr_o(ptr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid === 1'b1) wr_q.push_back({wr_addr, wr_data});
        if (sda_o === 1'b0) sda_low_seen = 1;
        if (scl_o === 1'b0) run_len++;
        else if (run_len > 0) begin stretch_runs.push_back(run_len); run_len = 0; end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
    endtask

    task automatic model_write(input logic [7:0] p, input logic [7:0] d[$]);
        int a = int'(p) % 16;
        exp_q.delete();
        foreach (d[i]) begin
            model_mem[a] = d[i];
            exp_q.push_back({4'(a), d[i]});
            a = (a + 1) % 16;
        end
        model_ptr = a;
    endtask

    task automatic scl_up();
        int n = 0;
        scl_m = 1'b1;
        while (scl_bus !== 1'b1 && n < 200) begin #10; n++; end
        if (scl_bus !== 1'b1) begin miscompares++; $display("FAIL scl_release got=%b want=1", scl_bus); end
    endtask

    task automatic send_bit(input logic b);
        #Q sda_m = b;
        #Q scl_up();
        #(2*Q) scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        #Q sda_m = 1'b1;
        #Q scl_up();
        #Q b = sda_bus;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_start();
        #Q sda_m = 1'b1;
        #Q scl_up();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #Q sda_m = 1'b0;
        #Q scl_up();
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(~ack);
    endtask

    task automatic write_txn(input logic [7:0] p, input logic [7:0] d[$], output int nacks);
        logic a;
        nacks = 0;
        wr_q.delete();
        bus_start();
        send_byte(8'h44, a); nacks += int'(!a);
        send_byte(p, a);     nacks += int'(!a);
        foreach (d[i]) begin send_byte(d[i], a); nacks += int'(!a); end
        bus_stop();
    endtask

    task automatic read_txn(input logic [7:0] p, input int n, output int nacks);
        logic a;
        logic [7:0] b;
        nacks = 0;
        rd_q.delete();
        bus_start();
        send_byte(8'h44, a); nacks += int'(!a);
        send_byte(p, a);     nacks += int'(!a);
        bus_start();
        send_byte(8'h45, a); nacks += int'(!a);
        for (int i = 0; i < n; i++) begin recv_byte(b, i != n - 1); rd_q.push_back(b); end
        bus_stop();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #(3*Q);
        vectors++; if (sda_o !== 1'b1) begin miscompares++; $display("FAIL reset_sda_o got=%b want=1", sda_o); end
        vectors++; if (scl_o !== 1'b1) begin miscompares++; $display("FAIL reset_scl_o got=%b want=1", scl_o); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid got=%b want=0", wr_valid); end
        vectors++; if (wr_addr !== 4'h0 || wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_bus got=%h/%h want=0/00", wr_addr, wr_data); end
        vectors++; if (ptr !== 4'h0) begin miscompares++; $display("FAIL reset_ptr got=%h want=0", ptr); end
        for (int i = 0; i < 16; i++) begin
            vectors++; if (dut.mem[i] !== 8'h00) begin miscompares++; $display("FAIL reset_mem[%0d] got=%h want=00", i, dut.mem[i]); end
        end
        rst = 1'b0;
        model_reset();
        #Q;
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        logic [7:0] d[$];
        d.push_back(8'hA5); d.push_back(8'h5A);
        wr_q.delete();
        bus_start();
        send_byte(8'h44, a0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy got=%b want=1", busy); end
        send_byte(8'h03, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h5A, a3);
        bus_stop();
        model_write(8'h03, d);
        vectors++; if ({a0, a1, a2, a3} !== 4'b1111) begin miscompares++; $display("FAIL write_acks got=%b want=1111", {a0, a1, a2, a3}); end
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL write_events got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL write_event%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
        end
        vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL write_ptr got=%0d want=%0d", ptr, model_ptr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after_stop got=%b want=0", busy); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        bus_start();
        send_byte(8'h44, a0);
        send_byte(8'h03, a1);
        bus_start();
        send_byte(8'h45, a2);
        recv_byte(b0, 1'b1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy_mid got=%b want=1", busy); end
        recv_byte(b1, 1'b0);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_nack got=%b want=0", busy); end
        bus_stop();
        model_ptr = 4;
        vectors++; if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL read_acks got=%b want=111", {a0, a1, a2}); end
        vectors++; if (b0 !== model_mem[3]) begin miscompares++; $display("FAIL read_byte0 got=%h want=%h", b0, model_mem[3]); end
        vectors++; if (b1 !== model_mem[4]) begin miscompares++; $display("FAIL read_byte1 got=%h want=%h", b1, model_mem[4]); end
        vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL read_ptr got=%0d want=%0d", ptr, model_ptr); end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        sda_low_seen = 0;
        wr_q.delete();
        bus_start(); send_byte(8'h46, a0); send_byte(8'h00, a1); bus_stop();
        bus_start(); send_byte(8'h00, a2); bus_stop();
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL mismatch_acks got=%b want=000", {a0, a1, a2}); end
        vectors++; if (sda_low_seen !== 1'b0) begin miscompares++; $display("FAIL mismatch_sda_driven got=%b want=0", sda_low_seen); end
        vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL mismatch_writes got=%0d want=0", wr_q.size()); end
        vectors++; if (int'(ptr) != model_ptr || busy !== 1'b0) begin miscompares++; $display("FAIL mismatch_state got=ptr%0d/busy%b want=ptr%0d/busy0", ptr, busy, model_ptr); end
    endtask

    task automatic test_wrap();
        int nacks;
        logic [7:0] d[$];
        d.push_back(8'h11); d.push_back(8'h22);
        write_txn(8'h0F, d, nacks);
        model_write(8'h0F, d);
        vectors++; if (nacks != 0) begin miscompares++; $display("FAIL wrap_nacks got=%0d want=0", nacks); end
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wrap_events got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wrap_event%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
        end
        vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL wrap_ptr got=%0d want=%0d", ptr, model_ptr); end
        read_txn(8'h0F, 2, nacks);
        vectors++; if (rd_q.size() != 2 || rd_q[0] !== model_mem[15] || rd_q[1] !== model_mem[0]) begin
            miscompares++; $display("FAIL wrap_read got=%p want=%h,%h", rd_q, model_mem[15], model_mem[0]);
        end
        vectors++; if (ptr !== 4'h0) begin miscompares++; $display("FAIL wrap_read_ptr got=%0d want=0", ptr); end
    endtask

    task automatic test_abort();
        logic a;
        wr_q.delete();
        bus_start();
        send_byte(8'h44, a);
        send_byte(8'h07, a);
        for (int i = 0; i < 4; i++) send_bit(1'(i % 2));
        bus_stop();
        model_ptr = 7;
        vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL abort_writes got=%0d want=0", wr_q.size()); end
        vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL abort_ptr got=%0d want=%0d", ptr, model_ptr); end
        vectors++; if (dut.mem[7] !== model_mem[7]) begin miscompares++; $display("FAIL abort_mem got=%h want=%h", dut.mem[7], model_mem[7]); end
    endtask

    task automatic test_random();
        int nacks, n, rp;
        logic [7:0] p;
        logic [7:0] d[$];
        for (int it = 0; it < 6; it++) begin
            d.delete();
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            write_txn(p, d, nacks);
            model_write(p, d);
            vectors++; if (nacks != 0) begin miscompares++; $display("FAIL rand%0d_write_nacks got=%0d want=0", it, nacks); end
            vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_events got=%0d want=%0d", it, wr_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < wr_q.size()) begin
                vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand%0d_event%0d got=%h want=%h", it, i, wr_q[i], exp_q[i]); end
            end
            vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL rand%0d_wptr got=%0d want=%0d", it, ptr, model_ptr); end
            rp = $urandom_range(0, 15);
            n = $urandom_range(1, 5);
            read_txn(8'(rp), n, nacks);
            vectors++; if (nacks != 0 || rd_q.size() != n) begin miscompares++; $display("FAIL rand%0d_read_len got=%0d/%0d want=0/%0d", it, nacks, rd_q.size(), n); end
            for (int k = 0; k < n && k < rd_q.size(); k++) begin
                vectors++; if (rd_q[k] !== model_mem[(rp + k) % 16]) begin miscompares++; $display("FAIL rand%0d_rd%0d got=%h want=%h", it, k, rd_q[k], model_mem[(rp + k) % 16]); end
            end
            model_ptr = (rp + n - 1) % 16;
            vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL rand%0d_rptr got=%0d want=%0d", it, ptr, model_ptr); end
        end
    endtask

    task automatic test_reset_mid();
        int nacks;
        logic a;
        logic [7:0] d[$];
        logic b;
        d.push_back(8'hA5);
        write_txn(8'h03, d, nacks);
        model_write(8'h03, d);
        bus_start();
        send_byte(8'h44, a); send_byte(8'h03, a);
        bus_start();
        send_byte(8'h45, a);
        for (int i = 0; i < 3; i++) recv_bit(b);
        #Q sda_m = 1'b1;
        #Q scl_up();
        #Q;
        vectors++; if (sda_o !== model_mem[3][4]) begin miscompares++; $display("FAIL rstmid_bit4 got=%b want=%b", sda_o, model_mem[3][4]); end
        #4 rst = 1'b1;
        #1;
        vectors++; if (sda_o !== 1'b1 || scl_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_release got=%b%b want=11", sda_o, scl_o); end
        #5;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            vectors++; if (dut.mem[i] !== model_mem[i]) begin miscompares++; $display("FAIL rstmid_mem[%0d] got=%h want=%h", i, dut.mem[i], model_mem[i]); end
        end
        vectors++; if (ptr !== 4'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_state got=ptr%0d/busy%b want=ptr0/busy0", ptr, busy); end
        #Q rst = 1'b0;
        #(2*Q);
        d.delete(); d.push_back(8'hC3); d.push_back(8'h3C);
        write_txn(8'h02, d, nacks);
        model_write(8'h02, d);
        vectors++; if (nacks != 0) begin miscompares++; $display("FAIL rstmid_nacks got=%0d want=0", nacks); end
        vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rstmid_events got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_event%0d got=%h want=%h", i, wr_q[i], exp_q[i]); end
        end
        vectors++; if (int'(ptr) != model_ptr) begin miscompares++; $display("FAIL rstmid_ptr got=%0d want=%0d", ptr, model_ptr); end
    endtask

    task automatic test_stretch();
`ifdef I2C_TGT_STRETCH_EN
        int nacks;
        logic [7:0] d[$];
        d.push_back(8'h77);
        stretch_runs.delete();
        write_txn(8'h08, d, nacks);
        model_write(8'h08, d);
        vectors++; if (nacks != 0 || wr_q.size() != 1) begin miscompares++; $display("FAIL stretch_xfer got=%0d/%0d want=0/1", nacks, wr_q.size()); end
        if (wr_q.size() == 1) begin
            vectors++; if (wr_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL stretch_event got=%h want=%h", wr_q[0], exp_q[0]); end
        end
        vectors++; if (stretch_runs.size() != 3) begin miscompares++; $display("FAIL stretch_count got=%0d want=3", stretch_runs.size()); end
        foreach (stretch_runs[i]) begin
            vectors++; if (stretch_runs[i] != 8) begin miscompares++; $display("FAIL stretch_len%0d got=%0d want=8", i, stretch_runs[i]); end
        end
`else
        vectors++; if (stretch_runs.size() != 0 || run_len != 0) begin miscompares++; $display("FAIL scl_never_low got=%0d runs want=0", stretch_runs.size()); end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_abort();
        test_random();
        test_reset_mid();
        test_stretch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
